// File: rtl/regfile_read_arbiter_pkg.sv
// Shared types and constants for the register-file read arbiter.
package rf_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int REG_ADDR_W = 5;
  localparam int WORD_W     = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/regfile_read_arbiter_if.sv
// Requester, shared-mux and response signals of the read arbiter, bundled as one bus.
interface regfile_read_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  import rf_arb_pkg::*;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_ready;
  logic [REG_ADDR_W-1:0]         mux_select;
  logic [WORD_W-1:0]             mux_data;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [WORD_W-1:0]             rsp_data;
  logic [ID_W-1:0]               rsp_id;

  modport slave (
    input  req_valid, req_addr, mux_data, rsp_ready,
    output req_ready, mux_select, rsp_valid, rsp_data, rsp_id
  );

  modport master (
    output req_valid, req_addr, mux_data, rsp_ready,
    input  req_ready, mux_select, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_idx_o,
  output logic               any_req_o
);

  logic            found;
  logic [ID_W-1:0] idx;

  always_comb begin
    // NOTE: every output and temporary gets a default first so no path leaves it unassigned (no latch).
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_req_o = |req_i;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr_i) + k) % NUM_REQ);
      if (en_i && !found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares one 32:1 register-file read mux among NUM_REQ requesters, round-robin,
// returning the captured word and requester ID over a valid/ready response.
module regfile_read_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  regfile_read_arbiter_if.slave  bus
);

  state_e                state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [REG_ADDR_W-1:0] sel_q, sel_d;
  logic [WORD_W-1:0]     rsp_data_q, rsp_data_d;

  logic                  grant_en;
  logic                  any_req;
  logic                  do_grant;
  logic [NUM_REQ-1:0]    gnt;
  logic [ID_W-1:0]       gnt_idx;

  // Reset is folded in so req_ready reads zero while reset is held.
  assign grant_en = reset_n && ((state_q == IDLE) || (state_q == RESP && bus.rsp_ready));
  assign do_grant = grant_en && any_req;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req_i     (bus.req_valid),
    .ptr_i     (ptr_q),
    .en_i      (grant_en),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_req_o (any_req)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = READ;
      READ:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = any_req ? READ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = gnt;
    bus.rsp_valid  = (state_q == RESP);
    bus.mux_select = sel_q;
    bus.rsp_data   = rsp_data_q;
    bus.rsp_id     = id_q;
  end

  // Grant bookkeeping and the word capture; r0 reads as zero regardless of the mux.
  always_comb begin
    ptr_d      = ptr_q;
    id_d       = id_q;
    sel_d      = sel_q;
    rsp_data_d = rsp_data_q;
    if (do_grant) begin
      ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      id_d  = gnt_idx;
      sel_d = bus.req_addr[gnt_idx*REG_ADDR_W +: REG_ADDR_W];
    end
    if (state_q == READ) begin
      rsp_data_d = (sel_q == ZERO_REG) ? '0 : bus.mux_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q      <= '0;
      id_q       <= '0;
      sel_q      <= ZERO_REG;
      rsp_data_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      sel_q      <= sel_d;
      rsp_data_q <= rsp_data_d;
    end
  end

endmodule
